// File: rtl/mem_wb_elastic_stage_pkg.sv
// Shared definitions for the MEM->WB elastic stage.
// Holds the default datapath widths, the jal link register, the payload
// packing order {jal, mem_to_reg, wen, waddr, npc, rdata, alu} and the
// encoding of the skid-buffer occupancy state.
package mem_wb_elastic_stage_pkg;

  localparam int DSIZE_DEF    = 32;
  localparam int ASIZE_DEF    = 5;
  localparam int ISIZE_DEF    = 32;
  localparam int LINK_REG_DEF = 31;

  // Packed payload width for arbitrary widths: 3 control bits + waddr + npc + rdata + alu.
  function automatic int wb_payload_w(input int dsize, input int asize, input int isize);
    return 3 + asize + isize + 2 * dsize;
  endfunction

  localparam int WB_PAYLOAD_W = wb_payload_w(DSIZE_DEF, ASIZE_DEF, ISIZE_DEF);

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/mem_wb_elastic_stage_skid_buf.sv
// elastic_skid_buf: generic two-entry valid/ready buffer with flush.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop every held entry (and any incoming one)
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data = head entry
// With SKID_EN=1 the head lives in main_r and a second entry parks in skid_r;
// in_ready then depends on registered state only. With SKID_EN=0 only main_r
// is used and in_ready = empty | out_ready.
module elastic_skid_buf
  import mem_wb_elastic_stage_pkg::*;
#(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_r, state_s;
  logic [W-1:0] main_r, main_s;
  logic [W-1:0] skid_r, skid_s;
  logic         accept_s, consume_s;

  assign out_valid = (state_r != SB_EMPTY);
  assign out_data  = main_r;
  assign accept_s  = in_valid & in_ready;
  assign consume_s = out_valid & out_ready;

  // Upstream ready: blocked during reset, otherwise from occupancy.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else if (SKID_EN) begin
      in_ready = (state_r != SB_TWO);
    end else begin
      in_ready = (state_r == SB_EMPTY) | out_ready;
    end
  end

  // Next occupancy and payload moves; flush overrides the state only.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    case (state_r)
      SB_EMPTY: begin
        if (accept_s) begin
          main_s  = in_data;
          state_s = SB_ONE;
        end else begin
          state_s = SB_EMPTY;
        end
      end
      SB_ONE: begin
        if (accept_s && !consume_s) begin
          skid_s  = in_data;
          state_s = SB_TWO;
        end else if (accept_s && consume_s) begin
          main_s  = in_data;
          state_s = SB_ONE;
        end else if (consume_s) begin
          state_s = SB_EMPTY;
        end else begin
          state_s = SB_ONE;
        end
      end
      SB_TWO: begin
        if (consume_s) begin
          main_s  = skid_r;
          state_s = SB_ONE;
        end else begin
          state_s = SB_TWO;
        end
      end
      default: begin
        state_s = SB_EMPTY;
      end
    endcase
    if (flush) begin
      state_s = SB_EMPTY;
    end else begin
      state_s = state_s;
    end
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SB_EMPTY;
      main_r  <= {W{1'b0}};
      skid_r  <= {W{1'b0}};
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
    end
  end

endmodule

// File: rtl/mem_wb_elastic_stage.sv
// mem_wb_elastic_stage: MEM->WB boundary with valid/ready flow control.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              MEM-side handshake
//   alu_result_in, rdata_dm_in     candidate writeback data
//   waddr_in, wen_in               destination register and write intent
//   mem_to_reg_in, jal_in, npc_in  writeback source selection / link value
//   flush                          discard held and incoming entries
//   out_valid/out_ready            WB-side handshake on the head entry
//   wb_wdata, wb_waddr, wb_wen     register-file write port
//   fwd_valid                      head writes a nonzero register
module mem_wb_elastic_stage
  import mem_wb_elastic_stage_pkg::*;
#(
  parameter int DSIZE    = DSIZE_DEF,
  parameter int ASIZE    = ASIZE_DEF,
  parameter int ISIZE    = ISIZE_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter bit SKID_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] alu_result_in,
  input  logic [DSIZE-1:0] rdata_dm_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  input  logic             mem_to_reg_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] npc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] wb_wdata,
  output logic [ASIZE-1:0] wb_waddr,
  output logic             wb_wen,
  output logic             fwd_valid
);

  localparam int PW = wb_payload_w(DSIZE, ASIZE, ISIZE);
  localparam logic [ASIZE-1:0] LINK_ADDR = ASIZE'(LINK_REG);

  logic [PW-1:0]    in_payload_s, head_payload_s;
  logic             head_jal_s, head_mtr_s, head_wen_s;
  logic [ASIZE-1:0] head_waddr_s;
  logic [ISIZE-1:0] head_npc_s;
  logic [DSIZE-1:0] head_rdata_s, head_alu_s, link_s;
  logic             writes_s;

  assign in_payload_s = {jal_in, mem_to_reg_in, wen_in, waddr_in, npc_in, rdata_dm_in, alu_result_in};

  elastic_skid_buf #(.W(PW), .SKID_EN(SKID_EN)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_payload_s)
  );

  assign {head_jal_s, head_mtr_s, head_wen_s, head_waddr_s,
          head_npc_s, head_rdata_s, head_alu_s} = head_payload_s;

  // Link value: npc zero-extended or truncated to the data width.
  if (ISIZE >= DSIZE) begin : g_link_trunc
    assign link_s = head_npc_s[DSIZE-1:0];
  end else begin : g_link_zext
    assign link_s = {{(DSIZE-ISIZE){1'b0}}, head_npc_s};
  end

  // Writeback source select; jal wins over mem_to_reg.
  always_comb begin
    wb_wdata = head_alu_s;
    if (head_jal_s) begin
      wb_wdata = link_s;
    end else if (head_mtr_s) begin
      wb_wdata = head_rdata_s;
    end else begin
      wb_wdata = head_alu_s;
    end
  end

  assign wb_waddr  = head_jal_s ? LINK_ADDR : head_waddr_s;
  // Writes to register 0 are suppressed; they must neither write nor forward.
  assign writes_s  = (head_wen_s | head_jal_s) & (wb_waddr != {ASIZE{1'b0}});
  assign fwd_valid = out_valid & writes_s;
  // No write may escape in a reset cycle even though the head is still valid.
  assign wb_wen    = out_valid & out_ready & writes_s & ~rst;

endmodule
